// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring division. Both
// retire one bit per clock, followed by one sign-fix/write cycle.
//
// Handshake: start is sampled on a rising edge only while busy=0. An accepted
// MULT/DIV raises busy on the following cycle and keeps it high through CALC
// and FIX. hi/lo are written on the FIX edge, and done pulses for exactly the
// next cycle, during which busy=0 and a new start is accepted. start while
// busy=1 is ignored. MTHI/MTLO write hi/lo on the accepting edge without
// leaving IDLE and never pulse done.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam int         CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;     // negate product / quotient
  logic               neg_r;     // remainder takes the dividend's sign
  logic               div_zero;
  logic [WIDTH-1:0]   opnd;      // multiplicand (mult) or divisor (div), as magnitude
  logic [2*WIDTH-1:0] acc;       // product accumulator; low half is the quotient for div
  logic [WIDTH-1:0]   rem;       // partial remainder (always < divisor)

  logic               op_signed;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy = (state != S_IDLE);

  // Operand magnitudes, one datapath step, and the sign-corrected results.
  // The magnitude of the most-negative value (2^(WIDTH-1)) is held as an
  // unsigned number, so it needs no special case.
  always_comb begin
    op_signed = (op == 3'd0) || (op == 3'd2);
    mag_a     = (op_signed && a[WIDTH-1]) ? -a : a;
    mag_b     = (op_signed && b[WIDTH-1]) ? -b : b;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    div_shift = {rem, acc[WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, opnd});
    prod_fix  = neg_q ? -acc : acc;
    quo_fix   = div_zero ? {WIDTH{1'b1}} : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    rem_fix   = neg_r ? -rem : rem;
  end

  // FSM, datapath registers and the HI/LO architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      rem      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op <= 3'd3) begin
              is_div   <= op[1];
              neg_q    <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r    <= op_signed && a[WIDTH-1];
              div_zero <= op[1] && (b == '0);
              rem      <= '0;
              cnt      <= '0;
              if (op[1]) begin
                opnd <= mag_b;
                acc  <= {{WIDTH{1'b0}}, mag_a};
              end else begin
                opnd <= mag_a;
                acc  <= {{WIDTH{1'b0}}, mag_b};
              end
              state <= S_CALC;
            end else if (op == 3'd4) begin
              hi <= a;
            end else if (op == 3'd5) begin
              lo <= a;
            end
          end
        end
        S_CALC: begin
          if (is_div) begin
            rem              <= WIDTH'(div_ok ? (div_shift - {1'b0, opnd}) : div_shift);
            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], div_ok};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= S_FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: exercises a WIDTH=32 and a WIDTH=8 instance against an
// arithmetic reference model (plain signed/unsigned integer math).
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, start8;
  logic [2:0]  op32, op8;
  logic [31:0] a32, b32, hi32, lo32;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy32, done32, busy8, done8;

  int checks   = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  mdu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  mdu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: HI/LO from ordinary integer arithmetic at width w.
  function automatic void model(input int w, input logic [2:0] o,
                                input longint unsigned x, input longint unsigned y,
                                output longint unsigned eh, output longint unsigned el);
    longint unsigned mask;
    longint unsigned pu;
    longint          sx, sy, p, q, r;
    mask = (64'd1 << w) - 64'd1;
    sx = longint'(x);
    sy = longint'(y);
    if (x[w-1]) sx = sx - (longint'(1) << w);
    if (y[w-1]) sy = sy - (longint'(1) << w);
    eh = 0;
    el = 0;
    case (o)
      3'd0: begin
        p  = sx * sy;
        pu = longint'(p);
        eh = (pu >> w) & mask;
        el = pu & mask;
      end
      3'd1: begin
        pu = x * y;
        eh = (pu >> w) & mask;
        el = pu & mask;
      end
      3'd2: begin
        if (sy == 0) begin
          el = mask;
          eh = x;
        end else begin
          q  = sx / sy;
          r  = sx % sy;
          pu = longint'(q);
          el = pu & mask;
          pu = longint'(r);
          eh = pu & mask;
        end
      end
      3'd3: begin
        if (y == 0) begin
          el = mask;
          eh = x;
        end else begin
          el = x / y;
          eh = x % y;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic longint unsigned cur_hi(input bit s);
    return s ? {56'd0, hi8} : {32'd0, hi32};
  endfunction
  function automatic longint unsigned cur_lo(input bit s);
    return s ? {56'd0, lo8} : {32'd0, lo32};
  endfunction
  function automatic logic cur_busy(input bit s);
    return s ? busy8 : busy32;
  endfunction
  function automatic logic cur_done(input bit s);
    return s ? done8 : done32;
  endfunction

  function automatic longint unsigned rand_val(input int w);
    longint unsigned mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return mask;
      3: return 64'd1 << (w - 1);
      4: return longint'($urandom_range(0, 20));
      default: return longint'($urandom) & mask;
    endcase
  endfunction

  // driver tasks
  task automatic drive(input bit s, input logic st, input logic [2:0] o,
                       input longint unsigned x, input longint unsigned y);
    if (s) begin
      start8 = st; op8 = o; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      start32 = st; op32 = o; a32 = x[31:0]; b32 = y[31:0];
    end
  endtask

  // Called at a falling edge; the next rising edge samples the request.
  task automatic issue(input bit s, input logic [2:0] o,
                       input longint unsigned x, input longint unsigned y);
    drive(s, 1'b1, o, x, y);
    @(negedge clk);
    drive(s, 1'b0, o, x, y);
  endtask

  // Issue one MULT/DIV and check latency, busy span, hold and result.
  // ign >= 0 injects an ignored DIVU request that many cycles after accept.
  task automatic run(input bit s, input logic [2:0] o, input longint unsigned x,
                     input longint unsigned y, input int ign, input bit b2b);
    int w;
    int k;
    int busy_n;
    bit held;
    longint unsigned eh, el, h0, l0;
    w = s ? 8 : 32;
    model(w, o, x, y, eh, el);
    h0 = cur_hi(s);
    l0 = cur_lo(s);
    issue(s, o, x, y);
    k = 0;
    busy_n = 0;
    held = 1'b1;
    while (!cur_done(s) && k <= w + 10) begin
      if (cur_busy(s)) busy_n++;
      if (cur_hi(s) != h0 || cur_lo(s) != l0) held = 1'b0;
      if (k == ign) drive(s, 1'b1, 3'd3, rand_val(w), 64'd3);
      else          drive(s, 1'b0, 3'd0, 64'd0, 64'd0);
      @(negedge clk);
      k++;
    end
    drive(s, 1'b0, 3'd0, 64'd0, 64'd0);
    check("latency", longint'(k), longint'(w + 1));
    check("busy_cycles", longint'(busy_n), longint'(w + 1));
    check("busy_in_done", {63'd0, cur_busy(s)}, 64'd0);
    check("hold_during_calc", {63'd0, held}, 64'd1);
    check("hi", cur_hi(s), eh);
    check("lo", cur_lo(s), el);
    if (!b2b) begin
      @(negedge clk);
      check("done_one_cycle", {63'd0, cur_done(s)}, 64'd0);
    end
  endtask

  initial begin : main
    bit seen;
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 3'd0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy32", {63'd0, busy32}, 64'd0);
    check("rst_done32", {63'd0, done32}, 64'd0);
    check("rst_hi32", cur_hi(1'b0), 64'd0);
    check("rst_lo32", cur_lo(1'b0), 64'd0);
    check("rst_hi8", cur_hi(1'b1), 64'd0);
    check("rst_lo8", cur_lo(1'b1), 64'd0);

    // directed cases from the plan
    run(1'b0, 3'd1, 64'hFFFFFFFF, 64'hFFFFFFFF, -1, 1'b0);
    check("multu_max_hi", cur_hi(1'b0), 64'hFFFFFFFE);
    check("multu_max_lo", cur_lo(1'b0), 64'h00000001);
    run(1'b0, 3'd0, 64'hFFFFFFFF, 64'd4, -1, 1'b0);
    run(1'b0, 3'd0, 64'h80000000, 64'h80000000, -1, 1'b0);
    check("mult_minmin_hi", cur_hi(1'b0), 64'h40000000);
    run(1'b0, 3'd2, 64'hFFFFFFF9, 64'd2, -1, 1'b0);
    check("div_m7_2_lo", cur_lo(1'b0), 64'hFFFFFFFD);
    check("div_m7_2_hi", cur_hi(1'b0), 64'hFFFFFFFF);
    run(1'b0, 3'd3, 64'd7, 64'd2, -1, 1'b0);
    run(1'b0, 3'd2, 64'h80000000, 64'hFFFFFFFF, -1, 1'b0);
    check("div_ovf_lo", cur_lo(1'b0), 64'h80000000);
    check("div_ovf_hi", cur_hi(1'b0), 64'd0);
    run(1'b0, 3'd3, 64'h12345678, 64'd0, -1, 1'b0);
    check("divu_zero_lo", cur_lo(1'b0), 64'hFFFFFFFF);
    check("divu_zero_hi", cur_hi(1'b0), 64'h12345678);
    run(1'b0, 3'd2, 64'hFFFFFFF9, 64'd0, -1, 1'b0);

    // MTHI / MTLO and reserved ops
    issue(1'b0, 3'd4, 64'hDEADBEEF, 64'd0);
    check("mthi_hi", cur_hi(1'b0), 64'hDEADBEEF);
    check("mthi_busy", {63'd0, busy32}, 64'd0);
    check("mthi_done", {63'd0, done32}, 64'd0);
    issue(1'b0, 3'd5, 64'd1, 64'd0);
    check("mtlo_lo", cur_lo(1'b0), 64'd1);
    check("mtlo_hi_kept", cur_hi(1'b0), 64'hDEADBEEF);
    check("mtlo_done", {63'd0, done32}, 64'd0);
    issue(1'b0, 3'd6, 64'h55, 64'h66);
    issue(1'b0, 3'd7, 64'h77, 64'h88);
    check("rsvd_hi", cur_hi(1'b0), 64'hDEADBEEF);
    check("rsvd_lo", cur_lo(1'b0), 64'd1);
    check("rsvd_busy", {63'd0, busy32}, 64'd0);

    // start while busy is ignored
    run(1'b0, 3'd0, 64'h00012345, 64'hFFFFFF00, 5, 1'b0);
    run(1'b0, 3'd1, 64'hCAFEF00D, 64'h0BADBEEF, 20, 1'b0);

    // reset mid-CALC discards everything
    issue(1'b0, 3'd0, 64'h11111111, 64'h22222222);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {63'd0, busy32}, 64'd0);
    check("midrst_hi", cur_hi(1'b0), 64'd0);
    check("midrst_lo", cur_lo(1'b0), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      if (done32 || busy32) seen = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_done", {63'd0, seen}, 64'd0);

    // back-to-back: new start in the done cycle
    run(1'b0, 3'd3, 64'd100, 64'd7, -1, 1'b1);
    run(1'b0, 3'd0, 64'hFFFFFFF0, 64'd3, -1, 1'b1);
    run(1'b0, 3'd2, 64'd1000, 64'hFFFFFFFD, -1, 1'b0);

    // WIDTH=8 directed
    run(1'b1, 3'd0, 64'h80, 64'h80, -1, 1'b0);
    check("w8_mult_hi", cur_hi(1'b1), 64'h40);
    check("w8_mult_lo", cur_lo(1'b1), 64'h00);
    run(1'b1, 3'd2, 64'h81, 64'h0A, -1, 1'b0);
    check("w8_div_lo", cur_lo(1'b1), 64'hF4);
    check("w8_div_hi", cur_hi(1'b1), 64'hF9);
    run(1'b1, 3'd2, 64'h80, 64'hFF, -1, 1'b0);

    // randomized against the model
    for (int i = 0; i < 40; i++) begin
      run(1'b0, 3'($urandom_range(0, 3)), rand_val(32), rand_val(32), -1, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      run(1'b1, 3'($urandom_range(0, 3)), rand_val(8), rand_val(8), -1, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
